// File: rtl/spi_shift_engine.sv
// SPI shift engine: generates SCK from a programmable divider, shifts the TX
// word out on MOSI, samples MISO into an RX word, and strobes frame completion
// back to the transfer-control FSM and into the RX FIFO.
module spi_shift_engine #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_frame_init,
   input  logic              i_in_transfer,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic              i_lsb_first,
   input  logic [DIV_W-1:0]  i_clk_div,
   input  logic              i_miso,
   output logic              o_sck,
   output logic              o_mosi,
   output logic              o_frame_done,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_wr,
   output logic              o_active
);

   // Edge counter must hold 0..2*DATA_W
   localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
   localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2 * DATA_W);
   localparam logic [EDGE_W-1:0] FIRST_EDGE = EDGE_W'(1);

   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [DIV_W-1:0]  div_cnt;
   logic [EDGE_W-1:0] edge_cnt;
   logic              cfg_cpol;
   logic              cfg_cpha;
   logic              cfg_lsb;
   logic [DIV_W-1:0]  cfg_div;

   logic [EDGE_W-1:0] edge_next_c;
   logic              tick_c;
   logic              sample_c;
   logic              shift_c;
   logic              last_c;
   logic [DATA_W-1:0] rx_next_c;
   logic [DATA_W-1:0] tx_shift_c;
   logic              mosi_next_c;

   // Edge classification and next-value datapath for the current cycle
   always_comb begin
      tick_c      = 1'b0;
      sample_c    = 1'b0;
      shift_c     = 1'b0;
      last_c      = 1'b0;
      edge_next_c = edge_cnt + EDGE_W'(1);
      rx_next_c   = rx_sr;
      tx_shift_c  = tx_sr;
      mosi_next_c = o_mosi;

      tick_c = o_active && i_in_transfer && (div_cnt == cfg_div);

      // Odd edges are leading, even edges trailing; cpha picks which one samples
      sample_c = tick_c && (edge_next_c[0] ^ cfg_cpha);

      if (cfg_cpha) begin
         shift_c = tick_c && edge_next_c[0] && (edge_next_c != FIRST_EDGE);
      end else begin
         shift_c = tick_c && !edge_next_c[0] && (edge_next_c != LAST_EDGE);
      end

      last_c = tick_c && (edge_next_c == LAST_EDGE);

      if (sample_c) begin
         if (cfg_lsb) begin
            rx_next_c = {i_miso, rx_sr[DATA_W-1:1]};
         end else begin
            rx_next_c = {rx_sr[DATA_W-2:0], i_miso};
         end
      end

      if (cfg_lsb) begin
         tx_shift_c  = {1'b0, tx_sr[DATA_W-1:1]};
         mosi_next_c = tx_sr[1];
      end else begin
         tx_shift_c  = {tx_sr[DATA_W-2:0], 1'b0};
         mosi_next_c = tx_sr[DATA_W-2];
      end
   end

   // Frame configuration, captured only when a frame is armed
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cfg_cpol <= 1'b0;
         cfg_cpha <= 1'b0;
         cfg_lsb  <= 1'b0;
         cfg_div  <= '0;
      end else if (i_frame_init) begin
         cfg_cpol <= i_cpol;
         cfg_cpha <= i_cpha;
         cfg_lsb  <= i_lsb_first;
         cfg_div  <= i_clk_div;
      end
   end

   // SCK timing: half-period divider, edge counter, clock level and active flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_cnt  <= '0;
         edge_cnt <= '0;
         o_sck    <= 1'b0;
         o_active <= 1'b0;
      end else if (i_frame_init) begin
         div_cnt  <= '0;
         edge_cnt <= '0;
         o_sck    <= i_cpol;
         o_active <= 1'b1;
      end else if (o_active) begin
         if (tick_c) begin
            div_cnt  <= '0;
            edge_cnt <= edge_next_c;
            o_sck    <= ~o_sck;
            if (last_c) begin
               o_active <= 1'b0;
            end
         end else if (i_in_transfer) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end else begin
         o_sck <= cfg_cpol;
      end
   end

   // Serial data: TX shift/MOSI drive and RX sampling
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_sr  <= '0;
         rx_sr  <= '0;
         o_mosi <= 1'b0;
      end else if (i_frame_init) begin
         tx_sr  <= i_tx_data;
         rx_sr  <= '0;
         o_mosi <= i_lsb_first ? i_tx_data[0] : i_tx_data[DATA_W-1];
      end else if (tick_c) begin
         rx_sr <= rx_next_c;
         if (shift_c) begin
            tx_sr  <= tx_shift_c;
            o_mosi <= mosi_next_c;
         end
      end
   end

   // Completion strobes and RX word hand-off; an aborting frame_init suppresses them
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_frame_done <= 1'b0;
         o_rx_wr      <= 1'b0;
         o_rx_data    <= '0;
      end else begin
         o_frame_done <= 1'b0;
         o_rx_wr      <= 1'b0;
         if (!i_frame_init && last_c) begin
            o_frame_done <= 1'b1;
            o_rx_wr      <= 1'b1;
            o_rx_data    <= rx_next_c;
         end
      end
   end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Datapath stage directly downstream of the SPI transfer-control FSM.
- Each frame is started by the FSM's o_frame_init and advanced while o_in_transfer is high.
- Per frame, the block generates SCK, shifts the TX word out on MOSI, samples MISO into an RX word, and returns a one-cycle frame-done pulse that the FSM consumes as i_frame_done.
- The completed RX word is also pushed to the RX FIFO.

Parameters:
- DATA_W, 8, frame length in bits (2..32).
- DIV_W, 8, width of the SCK half-period divider.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_frame_init  input  1  one-cycle pulse; latches i_tx_data and config, arms a new frame
- i_in_transfer  input  1  advance enable; frame progresses only while high
- i_tx_data  input  DATA_W  word popped from TX FIFO, valid with i_frame_init
- i_cpol  input  1  SCK idle level
- i_cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
- i_lsb_first  input  1  bit order
- i_clk_div  input  DIV_W  SCK half-period = i_clk_div+1 clk cycles
- i_miso  input  1  serial data in (already synchronised upstream)
- o_sck  output  1  SPI clock
- o_mosi  output  1  serial data out
- o_frame_done  output  1  one-cycle pulse, frame complete
- o_rx_data  output  DATA_W  last received word, held until next completion
- o_rx_wr  output  1  RX FIFO write strobe, coincident with o_frame_done
- o_active  output  1  frame armed and not yet complete

Behaviour:
- Reset (i_rst high at a clk edge): all outputs 0; shift registers, edge counter and divider cleared; active flag cleared; latched config = 0. Reset overrides everything, including mid-frame.
- Config latch: cpol, cpha, lsb_first and clk_div are latched on i_frame_init. Input changes mid-frame have no effect.
- Idle (not active): o_sck <= latched cpol; o_mosi holds.
- i_frame_init cycle:
  - tx_sr <= i_tx_data; o_mosi <= first bit (bit DATA_W-1 if MSB-first, else bit 0).
  - rx_sr cleared; div_cnt <= 0; edge_cnt <= 0; active <= 1; o_sck <= i_cpol.
  - frame_init has priority over in_transfer and over any in-flight frame. An in-flight frame is aborted silently: no done, no rx_wr.
- Active and i_in_transfer high:
  - div_cnt increments.
  - When div_cnt == clk_div: o_sck toggles, edge_cnt increments, div_cnt <= 0.
  - clk_div=0 toggles SCK every cycle.
- Active and i_in_transfer low: everything freezes (sck, counters, shift registers).
- Edges are numbered k = 1..2*DATA_W.
  - Odd k: leading edge. Even k: trailing edge.
  - Sample edges (rx_sr takes i_miso): odd k if cpha=0; even k if cpha=1.
  - MSB-first sampling: rx_sr <= {rx_sr[DATA_W-2:0], miso}. LSB-first sampling: rx_sr <= {miso, rx_sr[DATA_W-1:1]}.
  - Shift edges (next bit to o_mosi): cpha=0, even k < 2*DATA_W; cpha=1, odd k > 1.
  - The first bit is pre-driven at frame_init in both modes.
- Completion:
  - On the cycle edge 2*DATA_W occurs, active <= 0. SCK has returned to cpol because the edge count is even.
  - In the following cycle: o_frame_done=1, o_rx_wr=1, o_rx_data = final rx word.
  - Both strobes are high for exactly one cycle.
  - o_rx_data holds until the next completion.
- Cycle timing: with frame_init at cycle 0 and in_transfer continuous from cycle 1:
  - edge k occurs at cycle k*(clk_div+1);
  - o_frame_done is at cycle 2*DATA_W*(clk_div+1)+1.
- i_in_transfer high while not active: ignored. This covers the FSM's done-cycle and stray assertions.
- Back-to-back frames: frame_init arriving the cycle after o_frame_done starts the next frame normally. There is no minimum gap.

Test Plan:
- Mode 0, MSB-first, div=0, tx 0xA5, MISO looped to MOSI, frame_init @0, in_transfer 1..16 -> SCK edges @1..16, idles 0; o_frame_done and o_rx_wr high only @17; o_rx_data=0xA5.
- Mode 3, LSB-first, div=2, tx 0x3C, slave model returns 0xC3 -> SCK idles 1, half-period 3 cycles, MOSI sequence 0,0,1,1,1,1,0,0; rx_data=0xC3; done @49.
- Mode 1 and mode 2, div=1, tx 0x81 / slave 0x7E -> MOSI changes only on the specified shift edges; rx_data=0x7E; done @33.
- Pause: mode 0, div=0, in_transfer dropped for 5 cycles after edge 6 -> SCK and MOSI frozen; done @22; data correct.
- Abort: second frame_init (tx 0x5A) after edge 7 of a 0xFF frame -> no done for the first frame; done exactly once, 17 cycles later; rx_data matches the second frame.
- Reset mid-frame (i_rst after edge 9) -> next cycle all outputs 0 and o_active=0; a subsequent frame completes normally.
